// File: rtl/regfile_mp_pkg.sv
// Shared defaults, address-width helper and sequencer state encoding for regfile_mp.
// Optional build macro used by this block: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
package regfile_mp_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  function automatic int rf_aw(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: sweeps every register index once, writing zero, then enters RUN.
module regfile_clear_seq
  import regfile_mp_pkg::*;
#(
  parameter  int NREGS = RF_NREGS,
  localparam int AW    = rf_aw(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          init_done,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  rf_state_e     state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RF_INIT;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // NOTE: every variable driven here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    clr_we    = 1'b0;
    unique case (state)
      RF_INIT: begin
        clr_we = 1'b1;
        if (idx == AW'(NREGS - 1)) state_nxt = RF_RUN;
        else                       idx_nxt   = idx + 1'b1;
      end
      RF_RUN: ;
      default: state_nxt = RF_INIT;
    endcase
  end

  assign clr_addr  = idx;
  assign init_done = (state == RF_RUN);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard and post-reset clear sweep.
// Optional build macro: REGFILE_BYPASS_EN forwards same-cycle writes to the read ports.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter  int XLEN  = RF_XLEN,
  parameter  int NREGS = RF_NREGS,
  parameter  int NRD   = 2,
  parameter  int NWR   = 2,
  localparam int AW    = rf_aw(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_done,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NRD-1:0]    rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr
);

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  regfile_clear_seq #(.NREGS(NREGS)) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .init_done (init_done),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  // NOTE: storage deliberately has no reset so it maps onto RAM; the clear sweep zeroes it instead.
  logic [XLEN-1:0] regs [NREGS];

  // Lanes are visited in ascending order, so the highest matching lane's assignment lands last.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      regs[clr_addr] <= '0;
    end else if (init_done && !rst) begin
      for (int i = 0; i < NWR; i++) begin
        if (wr_en[i] && wr_addr[i*AW +: AW] != '0)
          regs[wr_addr[i*AW +: AW]] <= wr_data[i*XLEN +: XLEN];
      end
    end
  end

  logic [NREGS-1:0] busy, busy_nxt;

  // Alloc is applied after the write clears so a same-cycle new producer keeps the bit set.
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < NWR; i++) begin
      if (wr_en[i]) busy_nxt[wr_addr[i*AW +: AW]] = 1'b0;
    end
    if (alloc_en) busy_nxt[alloc_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)            busy <= '0;
    else if (init_done) busy <= busy_nxt;
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int j = 0; j < NRD; j++) begin
      if (init_done && rd_en[j] && rd_addr[j*AW +: AW] != '0) begin
        rd_data[j*XLEN +: XLEN] = regs[rd_addr[j*AW +: AW]];
        rd_busy[j]              = busy[rd_addr[j*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        for (int i = 0; i < NWR; i++) begin
          if (wr_en[i] && wr_addr[i*AW +: AW] == rd_addr[j*AW +: AW]) begin
            rd_data[j*XLEN +: XLEN] = wr_data[i*XLEN +: XLEN];
            rd_busy[j]              = 1'b0;
          end
        end
`endif
      end
    end
  end

endmodule
